axi_ram_slave: RTL

AXI4 slave (responder) backed by on-chip RAM. It is the far end of the DDR-side AXI4 master, used as a DDR stand-in for simulation and on-chip loopback, and as a small scratch memory on the interconnect. It has independent write and read engines that run concurrently, one outstanding transaction per direction.

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_ram_bank.sv | 46 ++++
 rtl/axi_ram_slave.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants, FSM encodings and helpers for the on-chip RAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_e;

    // Number of byte-offset bits in a full-width beat; also the only legal AxSIZE.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Only full-width FIXED/INCR bursts are served; everything else answers SLVERR.
    function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size, input int bb);
        return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != 3'(bb));
    endfunction

endpackage

// File: rtl/axi_ram_bank.sv
// True dual-port synchronous RAM: port A byte-masked write, port B registered read.
// Latency: read data appears in the output register one clock after rd_en_i.
// Backpressure: none; the output register holds its value while rd_en_i is low.
// Ports: clk_i/rst_i; wr_en_i, wr_addr_i, wr_data_i, wr_strb_i (write port);
//        rd_en_i, rd_addr_i, rd_data_o (read port, read-first on collision).
module axi_ram_bank #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_BITS-1:0]    wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_BITS-1:0]    rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_BITS)-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking update of mem_q means a same-cycle collision returns the old word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 responder backed by on-chip RAM; independent write and read engines, one burst each.
// Latency: AR handshake to first rvalid is 2 cycles; 1 beat/cycle on W and R thereafter.
// Backpressure: B and R held stable until bready/rready; AW/AR not accepted while busy.
// Ports: axi_clk, reset (async, active-high); s_axi_aw*/w*/b* write channels;
//        s_axi_ar*/r* read channels. lock/cache/prot/qos are not present.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_BITS  = 10,
    parameter int ID_WIDTH       = 4
) (
    input  logic                        axi_clk,
    input  logic                        reset,
    input  logic [ID_WIDTH-1:0]         s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [ID_WIDTH-1:0]         s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ID_WIDTH-1:0]         s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [ID_WIDTH-1:0]         s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int BB = addr_lsb(AXI_DATA_WIDTH);
    localparam logic [MEM_ADDR_BITS-1:0] IDX_ONE = MEM_ADDR_BITS'(1);

    // Only the word-index slice of the addresses is decoded; the rest aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    // ---------------- write engine ----------------
    wr_state_e                wr_state_q;
    logic                     awready_q, wready_q, bvalid_q;
    logic                     wr_err_q, wr_fixed_q;
    logic [ID_WIDTH-1:0]      wr_id_q;
    logic [MEM_ADDR_BITS-1:0] wr_idx_q;
    logic [7:0]               wr_len_q, wr_cnt_q;
    logic                     wr_beat, wr_last_beat;

    assign wr_beat      = wready_q && s_axi_wvalid;
    assign wr_last_beat = (wr_cnt_q == wr_len_q);

    always_ff @(posedge axi_clk or posedge reset) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            wr_fixed_q <= 1'b0;
            wr_id_q    <= '0;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awready_q && s_axi_awvalid) begin
                        wr_id_q    <= s_axi_awid;
                        wr_idx_q   <= s_axi_awaddr[BB +: MEM_ADDR_BITS];
                        wr_len_q   <= s_axi_awlen;
                        wr_err_q   <= req_err(s_axi_awburst, s_axi_awsize, BB);
                        wr_fixed_q <= (s_axi_awburst == BURST_FIXED);
                        wr_cnt_q   <= '0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_DATA;
                    end else begin
                        awready_q  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wr_beat) begin
                        // A misplaced wlast poisons the response but never changes burst length.
                        if (s_axi_wlast != wr_last_beat) begin
                            wr_err_q <= 1'b1;
                        end
                        if (!wr_fixed_q) begin
                            wr_idx_q <= wr_idx_q + IDX_ONE;
                        end
                        if (wr_last_beat) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            wr_state_q <= W_RESP;
                        end else begin
                            wr_cnt_q   <= wr_cnt_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = wr_id_q;
    assign s_axi_bresp   = wr_err_q ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read engine ----------------
    rd_state_e                rd_state_q;
    logic                     arready_q, rvalid_q, rlast_q;
    logic                     rd_err_q, rd_fixed_q;
    logic [ID_WIDTH-1:0]      rd_id_q;
    logic [MEM_ADDR_BITS-1:0] rd_idx_q;
    logic [7:0]               rd_len_q, rd_cnt_q;
    logic                     rd_en;
    logic [AXI_DATA_WIDTH-1:0] ram_rdata;

    // Prefetch the next word only when the current beat is consumed, so rdata holds under stall.
    assign rd_en = (rd_state_q == R_FETCH) || (rvalid_q && s_axi_rready && !rlast_q);

    always_ff @(posedge axi_clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_fixed_q <= 1'b0;
            rd_id_q    <= '0;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            if (rd_en && !rd_fixed_q) begin
                rd_idx_q <= rd_idx_q + IDX_ONE;
            end
            case (rd_state_q)
                R_IDLE: begin
                    if (arready_q && s_axi_arvalid) begin
                        rd_id_q    <= s_axi_arid;
                        rd_idx_q   <= s_axi_araddr[BB +: MEM_ADDR_BITS];
                        rd_len_q   <= s_axi_arlen;
                        rd_err_q   <= req_err(s_axi_arburst, s_axi_arsize, BB);
                        rd_fixed_q <= (s_axi_arburst == BURST_FIXED);
                        rd_cnt_q   <= '0;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_FETCH;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_FETCH: begin
                    rvalid_q   <= 1'b1;
                    rlast_q    <= (rd_len_q == 8'd0);
                    rd_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_cnt_q   <= rd_cnt_q + 8'd1;
                            rlast_q    <= ((rd_cnt_q + 8'd1) == rd_len_q);
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rd_id_q;
    assign s_axi_rresp   = rd_err_q ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rdata   = rd_err_q ? '0 : ram_rdata;

    axi_ram_bank #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .ADDR_BITS  (MEM_ADDR_BITS)
    ) u_bank (
        .clk_i      (axi_clk),
        .rst_i      (reset),
        .wr_en_i    (wr_beat && !wr_err_q),
        .wr_addr_i  (wr_idx_q),
        .wr_data_i  (s_axi_wdata),
        .wr_strb_i  (s_axi_wstrb),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_idx_q),
        .rd_data_o  (ram_rdata)
    );

endmodule
